// File: rtl/multdiv_controller.sv
// -----------------------------------------------------------------------------
// multdiv_controller
//
// Sequencing FSM for an iterative shift-add multiplier / shift-subtract
// divider. It accepts a MULT or DIV issue pulse, loads the datapath for one
// cycle, steps it N_STEPS times, and then presents a one-cycle result-ready
// strobe with an exception flag.
//
// Optional feature (macro MD_EARLY_TERM_EN):
//   When defined, a multiply leaves RUN as soon as the datapath reports that
//   the remaining multiplier bits are all zero. When undefined, mplier_zero is
//   ignored and every multiply takes the full N_STEPS iterations.
//
// Parameters:
//   N_STEPS        datapath iterations per operation (1..32)
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous active-high reset
//   ctrl_MULT      in   issue multiply (wins over ctrl_DIV)
//   ctrl_DIV       in   issue divide
//   flush          in   kill the in-flight operation (wins over ctrl)
//   divisor_zero   in   latched divisor is zero
//   mplier_zero    in   remaining multiplier bits are zero
//   ovf_in         in   product overflows 32 bits
//   dp_load        out  datapath load / clear accumulators
//   dp_step        out  datapath performs one iteration
//   dp_isDiv       out  datapath mode: 1 divide, 0 multiply
//   step_count     out  current iteration index (0 outside RUN)
//   data_inProg    out  operation in flight (LOAD or RUN)
//   data_resultRDY out  result valid this cycle
//   data_exception out  divide-by-zero / multiply overflow, with resultRDY
// -----------------------------------------------------------------------------
module multdiv_controller #(
    parameter int N_STEPS = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ctrl_MULT,
    input  logic       ctrl_DIV,
    input  logic       flush,
    input  logic       divisor_zero,
    input  logic       mplier_zero,
    input  logic       ovf_in,
    output logic       dp_load,
    output logic       dp_step,
    output logic       dp_isDiv,
    output logic [4:0] step_count,
    output logic       data_inProg,
    output logic       data_resultRDY,
    output logic       data_exception
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'(N_STEPS - 1);

    state_t     state_q, state_d;
    logic [4:0] step_q,  step_d;
    logic       isdiv_q, isdiv_d;
    logic       exc_q,   exc_d;
    logic       early_term_s;

`ifdef MD_EARLY_TERM_EN
    // A multiply may stop once no multiplier bits remain to be processed.
    assign early_term_s = ~isdiv_q & mplier_zero;
`else
    // mplier_zero is deliberately ignored: multiplies always run every step.
    assign early_term_s = 1'b0 & mplier_zero;
`endif

    // State, counter, mode and exception registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= 5'd0;
            isdiv_q <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            isdiv_q <= isdiv_d;
            exc_q   <= exc_d;
        end
    end

    // Next-state logic. Flush beats any issue; an issue is accepted in every
    // state, which restarts (aborts) an operation still in LOAD or RUN.
    always_comb begin
        state_d = state_q;
        step_d  = 5'd0;
        isdiv_d = isdiv_q;
        exc_d   = exc_q;
        if (flush) begin
            state_d = ST_IDLE;
            exc_d   = 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            state_d = ST_LOAD;
            isdiv_d = ~ctrl_MULT;
            exc_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    if (isdiv_q && divisor_zero) begin
                        // Divide by zero: skip iterating, report at once.
                        state_d = ST_DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (early_term_s || (step_q == LAST_STEP)) begin
                        state_d = ST_DONE;
                        // Only multiplies can overflow; divide exceptions
                        // come solely from the divisor_zero path above.
                        exc_d   = isdiv_q ? 1'b0 : ovf_in;
                    end else begin
                        state_d = ST_RUN;
                        step_d  = step_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    exc_d   = 1'b0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the registered state and counter.
    assign dp_load        = (state_q == ST_LOAD);
    assign dp_step        = (state_q == ST_RUN);
    assign dp_isDiv       = isdiv_q;
    assign step_count     = step_q;
    assign data_inProg    = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign data_resultRDY = (state_q == ST_DONE);
    assign data_exception = (state_q == ST_DONE) && exc_q;

endmodule

// File: tb/tb_multdiv_controller.sv
// -----------------------------------------------------------------------------
// tb_multdiv_controller
//
// Self-checking bench for multdiv_controller. A reference model tracks each
// operation as an "age" (cycles since issue: 0 = load cycle, 1..N = iteration
// cycles, N+1 = result cycle, -1 = nothing in flight) and predicts every
// output each cycle. Directed scenarios cover the latency, divide-by-zero,
// abort/restart, flush, async reset and back-to-back issue cases; a random
// phase follows.
// -----------------------------------------------------------------------------
module tb_multdiv_controller;

    localparam int N = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ctrl_MULT = 1'b0;
    logic       ctrl_DIV = 1'b0;
    logic       flush = 1'b0;
    logic       divisor_zero = 1'b0;
    logic       mplier_zero = 1'b0;
    logic       ovf_in = 1'b0;
    logic       dp_load;
    logic       dp_step;
    logic       dp_isDiv;
    logic [4:0] step_count;
    logic       data_inProg;
    logic       data_resultRDY;
    logic       data_exception;

    multdiv_controller #(.N_STEPS(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .flush          (flush),
        .divisor_zero   (divisor_zero),
        .mplier_zero    (mplier_zero),
        .ovf_in         (ovf_in),
        .dp_load        (dp_load),
        .dp_step        (dp_step),
        .dp_isDiv       (dp_isDiv),
        .step_count     (step_count),
        .data_inProg    (data_inProg),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    int   age     = -1;
    logic m_isdiv = 1'b0;
    logic m_exc   = 1'b0;

    // per-scenario observation tallies
    int cyc = 0;
    int obs_steps = 0;
    int obs_rdy = 0;
    int last_rdy = -1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Advance the model across one rising edge using the inputs in force.
    task automatic model_edge();
        logic early;
`ifdef MD_EARLY_TERM_EN
        early = !m_isdiv && mplier_zero;
`else
        early = 1'b0;
`endif
        if (reset) begin
            age = -1; m_isdiv = 1'b0; m_exc = 1'b0;
        end else if (flush) begin
            age = -1;
        end else if (ctrl_MULT || ctrl_DIV) begin
            age = 0; m_isdiv = !ctrl_MULT; m_exc = 1'b0;
        end else if (age == 0) begin
            if (m_isdiv && divisor_zero) begin
                age = N + 1; m_exc = 1'b1;
            end else begin
                age = 1;
            end
        end else if (age >= 1 && age <= N) begin
            if (age == N || early) begin
                age = N + 1; m_exc = m_isdiv ? 1'b0 : ovf_in;
            end else begin
                age = age + 1;
            end
        end else if (age == N + 1) begin
            age = -1;
        end
    endtask

    task automatic check_outputs();
        int e_step;
        e_step = (age >= 1 && age <= N) ? 1 : 0;
        check_val("dp_load",     dp_load,        (age == 0) ? 1 : 0);
        check_val("dp_step",     dp_step,        e_step);
        check_val("step_count",  step_count,     e_step ? age - 1 : 0);
        check_val("inProg",      data_inProg,    (age >= 0 && age <= N) ? 1 : 0);
        check_val("resultRDY",   data_resultRDY, (age == N + 1) ? 1 : 0);
        if (age == N + 1) check_val("exception", data_exception, m_exc);
        if (age >= 0)     check_val("dp_isDiv",  dp_isDiv,       m_isdiv);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_outs"},
                  {dp_load, dp_step, dp_isDiv, step_count, data_inProg,
                   data_resultRDY, data_exception}, 0);
    endtask

    // One clock: model follows the edge, outputs checked at the falling edge.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cyc++;
        if (dp_step) obs_steps++;
        if (data_resultRDY) begin obs_rdy++; last_rdy = cyc; end
        check_outputs();
    endtask

    task automatic clear_tally();
        cyc = 0; obs_steps = 0; obs_rdy = 0; last_rdy = -1;
    endtask

    task automatic idle_cycles(input int n);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; flush = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // reset state
        #1;
        check_all_zero("reset");
        @(negedge clock);
        check_all_zero("reset_held");
        reset = 1'b0;
        idle_cycles(2);

        // plain multiply: load at 1, steps 2..33, result at 34
        clear_tally();
        ctrl_MULT = 1'b1; ovf_in = 1'b0;
        cycle();
        idle_cycles(37);
        check_val("mult_steps",   obs_steps, 32);
        check_val("mult_rdy_cnt", obs_rdy,   1);
        check_val("mult_rdy_at",  last_rdy,  34);

        // divide by zero: result at cycle 2, never steps
        clear_tally();
        ctrl_DIV = 1'b1; divisor_zero = 1'b1;
        cycle();
        idle_cycles(4);
        check_val("dz_steps",  obs_steps, 0);
        check_val("dz_rdy_at", last_rdy,  2);
        divisor_zero = 1'b0;

        // simultaneous issue (MULT wins), then DIV aborts at step 10
        clear_tally();
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
        cycle();
        check_val("both_isdiv", dp_isDiv, 0);
        idle_cycles(11);
        check_val("abort_at_step", step_count, 10);
        clear_tally();
        ctrl_DIV = 1'b1;
        cycle();
        check_val("abort_load",  dp_load,  1);
        check_val("abort_isdiv", dp_isDiv, 1);
        idle_cycles(37);
        check_val("abort_rdy_cnt", obs_rdy,  1);
        check_val("abort_rdy_at",  last_rdy, 34);

        // flush at step 5
        ctrl_MULT = 1'b1;
        cycle();
        idle_cycles(6);
        check_val("flush_at_step", step_count, 5);
        clear_tally();
        flush = 1'b1; ctrl_DIV = 1'b1;
        cycle();
        check_val("flush_inprog", data_inProg, 0);
        idle_cycles(40);
        check_val("flush_rdy_cnt", obs_rdy, 0);

        // async reset at step 20
        ctrl_MULT = 1'b1;
        cycle();
        idle_cycles(21);
        check_val("rst_at_step", step_count, 20);
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        clear_tally();
        cycle();
        reset = 1'b0;
        idle_cycles(40);
        check_val("rst_rdy_cnt", obs_rdy, 0);

        // issue during the DONE cycle
        ctrl_MULT = 1'b1; ovf_in = 1'b1;
        cycle();
        idle_cycles(33);
        check_val("done_rdy", data_resultRDY, 1);
        check_val("done_exc", data_exception, 1);
        ctrl_MULT = 1'b1; ovf_in = 1'b0;
        cycle();
        check_val("done_reload", dp_load, 1);
        idle_cycles(36);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            ctrl_MULT    = ($urandom_range(0, 39) == 0);
            ctrl_DIV     = ($urandom_range(0, 39) == 0);
            flush        = ($urandom_range(0, 79) == 0);
            divisor_zero = ($urandom_range(0, 3) == 0);
            mplier_zero  = ($urandom_range(0, 7) == 0);
            ovf_in       = $urandom_range(0, 1);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
